// File: rtl/alu_mc_if.sv
// Request/response bundle between the accumulator-side control and the multi-cycle ALU.
interface alu_mc_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         carry;
    logic         zero;
    logic         neg;
    logic         busy;
    logic         done;

    modport master (
        output start, op, a_in, b_in, cin,
        input  result, result_hi, carry, zero, neg, busy, done
    );

    modport slave (
        input  start, op, a_in, b_in, cin,
        output result, result_hi, carry, zero, neg, busy, done
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shifts by s, and
// an iterative W x W -> 2W unsigned multiply behind a start/busy/done handshake.
module alu_mc #(
    parameter  int unsigned W  = 8,
    localparam int unsigned SW = $clog2(W)
) (
    input logic     CLK,
    input logic     Reset,
    alu_mc_if.slave bus
);
    localparam int unsigned CW = SW + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    logic [0:0]     state, state_d;
    logic [CW-1:0]  count, count_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           cin_q, cin_d;
    logic [2*W-1:0] prod, prod_d;
    logic [W-1:0]   result, result_d;
    logic [W-1:0]   result_hi, result_hi_d;
    logic           carry, carry_d;
    logic           zero, zero_d;
    logic           neg, neg_d;
    logic           done, done_d;

    logic [W:0]     sum, diff, mac;
    logic [W-1:0]   shl_q, shr_q;
    logic [2*W-1:0] prod_step;
    logic           fin, fin_carry;
    logic [W-1:0]   fin_lo, fin_hi;

    // Next-state, datapath step and output-register update
    always_comb begin
        state_d     = state;
        count_d     = count;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        prod_d      = prod;
        result_d    = result;
        result_hi_d = result_hi;
        carry_d     = carry;
        zero_d      = zero;
        neg_d       = neg;
        done_d      = 1'b0;
        fin         = 1'b0;
        fin_carry   = 1'b0;
        fin_lo      = '0;
        fin_hi      = '0;

        sum       = {1'b0, bus.a_in} + {1'b0, bus.b_in} + (W+1)'(bus.cin);
        diff      = {1'b0, bus.a_in} - {1'b0, bus.b_in};
        shl_q     = {a_q[W-2:0], cin_q};
        shr_q     = {cin_q, a_q[W-1:1]};
        // Right-shifting multiplier: add multiplicand into the upper half, then shift
        mac       = {1'b0, prod[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : (W+1)'(0));
        prod_step = {mac, prod[W-1:1]};

        if (state == IDLE) begin
            if (bus.start) begin
                op_d  = bus.op;
                a_d   = bus.a_in;
                b_d   = bus.b_in;
                cin_d = bus.cin;
                case (bus.op)
                    OP_ADD: begin fin = 1'b1; fin_lo = sum[W-1:0];  fin_carry = sum[W];   end
                    OP_SUB: begin fin = 1'b1; fin_lo = diff[W-1:0]; fin_carry = ~diff[W]; end
                    OP_AND: begin fin = 1'b1; fin_lo = bus.a_in & bus.b_in; end
                    OP_OR:  begin fin = 1'b1; fin_lo = bus.a_in | bus.b_in; end
                    OP_XOR: begin fin = 1'b1; fin_lo = bus.a_in ^ bus.b_in; end
                    OP_SHL, OP_SHR: begin
                        if (bus.b_in[SW-1:0] == '0) begin
                            fin    = 1'b1;
                            fin_lo = bus.a_in;
                        end else begin
                            state_d = EXEC;
                            count_d = CW'(bus.b_in[SW-1:0]);
                        end
                    end
                    OP_MUL: begin
                        state_d = EXEC;
                        count_d = CW'(W);
                        prod_d  = '0;
                    end
                    default: ;
                endcase
            end
        end else begin
            count_d = count - CW'(1);
            case (op_q)
                OP_SHL: begin
                    a_d = shl_q;
                    if (count == CW'(1)) begin
                        fin = 1'b1; fin_lo = shl_q; fin_carry = a_q[W-1]; state_d = IDLE;
                    end
                end
                OP_SHR: begin
                    a_d = shr_q;
                    if (count == CW'(1)) begin
                        fin = 1'b1; fin_lo = shr_q; fin_carry = a_q[0]; state_d = IDLE;
                    end
                end
                OP_MUL: begin
                    prod_d = prod_step;
                    b_d    = {1'b0, b_q[W-1:1]};
                    if (count == CW'(1)) begin
                        fin     = 1'b1;
                        fin_lo  = prod_step[W-1:0];
                        fin_hi  = prod_step[2*W-1:W];
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end

        if (fin) begin
            result_d    = fin_lo;
            result_hi_d = fin_hi;
            carry_d     = fin_carry;
            zero_d      = ({fin_hi, fin_lo} == '0);
            neg_d       = fin_lo[W-1];
            done_d      = 1'b1;
        end
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state     <= IDLE;
            count     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            prod      <= '0;
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cin_q     <= cin_d;
            prod      <= prod_d;
            result    <= result_d;
            result_hi <= result_hi_d;
            carry     <= carry_d;
            zero      <= zero_d;
            neg       <= neg_d;
            done      <= done_d;
        end
    end

    assign bus.result    = result;
    assign bus.result_hi = result_hi;
    assign bus.carry     = carry;
    assign bus.zero      = zero;
    assign bus.neg       = neg;
    assign bus.busy      = (state == EXEC);
    assign bus.done      = done;
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU: the next generation of the processor's combinational ALU. It adds a registered result and flags, a start/busy/done handshake, barrel-free iterative shifts by a variable amount, and an iterative unsigned W×W→2W multiply. It sits between the register file/accumulator and the writeback mux. The control FSM stalls the PC while `busy` is high.

## Interface
Parameters:
- `W`, 8, datapath width in bits; a power of two, ≥4.
- `SW`, `$clog2(W)`, shift-amount width, derived and not overridden.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
- `a_in`  in  W  operand A (accumulator side).
- `b_in`  in  W  operand B; for SHL/SHR only `b_in[SW-1:0]` is used, as the shift amount s.
- `cin`  in  1  carry-in for ADD; fill bit for SHL/SHR.
- `result`  out  W  low word of the result.
- `result_hi`  out  W  high word of the product (MUL only; 0 otherwise).
- `carry`  out  1  carry / no-borrow / last bit shifted out.
- `zero`  out  1  result (and `result_hi` for MUL) all zero.
- `neg`  out  1  `result[W-1]`.
- `busy`  out  1  multi-cycle op in progress.
- `done`  out  1  one-cycle pulse: outputs are valid and new.

## Operation
- FSM with two states, IDLE and EXEC. `busy` = (state==EXEC).
- In IDLE, `start`=1 latches `op`, `a_in`, `b_in` and `cin`. Inputs are don't-care after that edge.
- Single-cycle ops are ADD, SUB, AND, OR, XOR, and SHL/SHR with s=0. The result, flags and `done` are registered at the accepting edge. The state stays IDLE.
- SHL/SHR with s>0:
  - Accepting edge: go to EXEC with count=s.
  - Each EXEC edge performs one 1-bit shift with `cin` filled in and decrements count.
  - The edge that takes count to 0 registers the result, sets `carry` to the last bit shifted out, pulses `done`, and returns to IDLE.
- MUL:
  - Accepting edge: go to EXEC with count=W and a 2W partial-product register cleared.
  - Each EXEC edge performs one shift-add step (LSB-first over B).
  - The final step writes {`result_hi`, `result`} = A×B (unsigned), sets `carry`=0, pulses `done`, and returns to IDLE.
- Arithmetic:
  - ADD: {`carry`,`result`} = A+B+`cin` (W+1 bits).
  - SUB: `result` = A−B mod 2^W; `carry` = 1 when A≥B unsigned (no borrow); `cin` is ignored.
  - AND/OR/XOR: `carry`=0.
  - SHL/SHR with s=0: `result`=A, `carry`=0.
- `result_hi` = 0 for all ops except MUL.
- `zero` is computed on the full registered result (2W bits for MUL). `neg` = `result[W-1]` for all ops.
- Outputs hold their last values until the next `done`. Intermediate EXEC values never appear on `result`.
- `start` while `busy`=1 is ignored, with no queueing.
- Reset=0 at any edge, including mid-EXEC: state IDLE, count 0, all outputs 0 (`result`, `result_hi`, `carry`, `zero`, `neg`, `busy`, `done`), and the partial product is cleared. No `done` is produced for an aborted op.

## Timing
- Cycle numbering: `start` is high and accepted in cycle 0.
- Single-cycle ops: `done` high in cycle 1, with outputs valid from cycle 1.
- SHL/SHR with s>0: `busy` high in cycles 1..s; `done` high in cycle s+1.
- MUL: `busy` high in cycles 1..W; `done` high in cycle W+1.
- `done` is high for exactly one cycle. `done` and `busy` are never high together.
- Back-to-back: `start` in the `done` cycle is accepted, giving zero bubble.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- Reset=0 for 2 cycles -> all outputs 0. Then ADD A=8'hFF, B=8'h01, cin=0 -> cycle 1: `result`=8'h00, `carry`=1, `zero`=1, `done`=1, `busy` never high.
- SUB A=8'h05, B=8'h07 -> `result`=8'hFE, `carry`=0, `neg`=1. Then SUB A=8'h07, B=8'h07 -> `result`=0, `carry`=1, `zero`=1.
- SHL A=8'hB3, b_in[2:0]=3, cin=1 -> `busy` in cycles 1–3; cycle 4: `result`=8'h9F, `carry`=1, `done`=1. SHR with s=0 -> `result`=A, `done` in cycle 1.
- MUL A=8'hFF, B=8'hFF -> `busy` in cycles 1–8; cycle 9: `result`=8'h01, `result_hi`=8'hFE, `zero`=0. `start` pulsed in cycle 4 with different operands is ignored, and the result is unchanged.
- MUL started, then Reset=0 in cycle 5 -> all outputs 0 next cycle and no `done`. After release, ADD 3+4 -> `result`=8'h07 in cycle 1.
- Back-to-back: XOR 8'hF0^8'h0F, then AND issued in the `done` cycle -> `result`=8'hFF, followed by the AND result one cycle later. Repeat the suite with W=16 (MUL 16'hFFFF² -> hi 16'hFFFE, lo 16'h0001, `done` in cycle 17).
